avl_rect_fill: RTL and testbench

Parametrised Avalon-MM write master that fills an axis-aligned rectangle of a linear 32-bit framebuffer with one colour. It is the configurable successor of the fixed-rectangle painter in the MTL display path:
- Rectangle origin, size and colour arrive per command with a start/busy/done handshake.
- The rectangle is clipped to the frame.
- Rows are written as Avalon bursts of up to MAX_BURST beats.

It sits between the application control logic and the SDRAM/framebuffer Avalon slave.

---
 rtl/avl_rect_fill.sv | 200 ++++++++++++++++++++
 tb/tb_avl_rect_fill.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/avl_rect_fill.sv
`default_nettype none
// ============================================================================
//  Module   : avl_rect_fill
//  Purpose  : Avalon-MM write master that fills an axis-aligned rectangle of
//             a linear 32-bit-per-pixel framebuffer with a single colour.
//             The rectangle is clipped to the frame and each row is emitted
//             as bursts of up to MAX_BURST beats.
//  Config   : AVL_BURST_EN - when defined, rows are written as multi-beat
//             bursts; when undefined, every pixel is its own single-beat
//             transaction (burstcount=1, burstbegin=1 on every beat).
//  Ports    : iCLK/iRST_n          clock, asynchronous active-low reset
//             iStart, iX0, iY0,    command request and rectangle origin,
//             iW, iH, iColor       size and fill colour (latched in IDLE)
//             oBusy, oDone         command in progress / completion pulse
//             avl_*                Avalon-MM write master to the framebuffer
//  Revision : 1.0 - initial release
// ============================================================================
module avl_rect_fill #(
   parameter int          FRAME_W   = 800,
   parameter int          FRAME_H   = 480,
   parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
   parameter int          MAX_BURST = 16,
   parameter int          BCW       = 5,
   parameter int          XW        = 10,
   parameter int          YW        = 10
) (
   input  logic           iCLK,
   input  logic           iRST_n,
   input  logic           iStart,
   input  logic [XW-1:0]  iX0,
   input  logic [YW-1:0]  iY0,
   input  logic [XW-1:0]  iW,
   input  logic [YW-1:0]  iH,
   input  logic [31:0]    iColor,
   output logic           oBusy,
   output logic           oDone,
   input  logic           avl_waitrequest,
   output logic [31:0]    avl_address,
   output logic [31:0]    avl_writedata,
   output logic           avl_write,
   output logic           avl_read,
   output logic           avl_burstbegin,
   output logic [BCW-1:0] avl_burstcount
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_FIN   = 2'd3;

`ifdef AVL_BURST_EN
   localparam int BURST_LEN = MAX_BURST;
`else
   // Single-beat mode: MAX_BURST has no effect on the burst length.
   localparam int BURST_LEN = (MAX_BURST > 0) ? 1 : 1;
`endif

   localparam logic [31:0] FW     = 32'(FRAME_W);
   localparam logic [31:0] FH     = 32'(FRAME_H);
   localparam logic [31:0] BL     = 32'(BURST_LEN);
   localparam logic [31:0] STRIDE = 32'(FRAME_W * 4);

   logic [1:0]    state, state_next;
   logic [XW-1:0] x0, w;
   logic [YW-1:0] y0, h;
   logic [31:0]   color;
   logic [31:0]   row_addr;    // address of the first pixel of the current row
   logic [31:0]   row_rem;     // pixels of the row not yet covered by a burst
   logic [31:0]   rows_rem;    // rows still to do after the current one
   logic [31:0]   beats_left;  // beats of the current burst still to accept

   logic [31:0] x0_32, y0_32, w_32, h_32;
   logic [31:0] ew_raw, eh_raw, ew, eh, origin, first_len, next_len;
   logic        empty, accept, last_beat;

   // ---- clipping and address arithmetic (all in 32 bits) ----
   assign x0_32  = 32'(x0);
   assign y0_32  = 32'(y0);
   assign w_32   = 32'(w);
   assign h_32   = 32'(h);
   // These wrap when the origin is off-frame; empty catches that case first.
   assign ew_raw = FW - x0_32;
   assign eh_raw = FH - y0_32;
   assign ew     = (w_32 < ew_raw) ? w_32 : ew_raw;
   assign eh     = (h_32 < eh_raw) ? h_32 : eh_raw;
   assign empty  = (x0_32 >= FW) || (y0_32 >= FH) || (ew == 32'd0) || (eh == 32'd0);
   assign origin = BASE_ADDR + ((y0_32 * FW + x0_32) << 2);

   // Length of the first burst of a row, and of the next burst within a row.
   assign first_len = (ew < BL) ? ew : BL;
   assign next_len  = (row_rem < BL) ? row_rem : BL;

   assign accept    = (state == S_WRITE) && !avl_waitrequest;
   assign last_beat = (beats_left == 32'd1);

   // ---- FSM: state register ----
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) state <= S_IDLE;
      else         state <= state_next;
   end

   // ---- FSM: next state ----
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (iStart) state_next = S_SETUP;
         S_SETUP: state_next = empty ? S_FIN : S_WRITE;
         S_WRITE: if (accept && last_beat && (row_rem == 32'd0) && (rows_rem == 32'd0))
                     state_next = S_FIN;
         S_FIN:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      oBusy     = 1'b0;
      oDone     = 1'b0;
      avl_write = 1'b0;
      case (state)
         S_SETUP: oBusy = 1'b1;
         S_WRITE: begin oBusy = 1'b1; avl_write = 1'b1; end
         S_FIN:   begin oBusy = 1'b1; oDone = 1'b1; end
         default: ;
      endcase
   end

   assign avl_read      = 1'b0;
   assign avl_writedata = color;

   // ---- datapath: command latch, burst bookkeeping, Avalon outputs ----
   // Bus-visible registers only move on an accepted beat, so everything is
   // held for free while the slave stalls.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         x0             <= '0;
         y0             <= '0;
         w              <= '0;
         h              <= '0;
         color          <= '0;
         row_addr       <= '0;
         row_rem        <= '0;
         rows_rem       <= '0;
         beats_left     <= '0;
         avl_address    <= '0;
         avl_burstcount <= '0;
         avl_burstbegin <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (iStart) begin
                  x0    <= iX0;
                  y0    <= iY0;
                  w     <= iW;
                  h     <= iH;
                  color <= iColor;
               end
            end
            S_SETUP: begin
               if (!empty) begin
                  row_addr       <= origin;
                  avl_address    <= origin;
                  avl_burstcount <= first_len[BCW-1:0];
                  beats_left     <= first_len;
                  row_rem        <= ew - first_len;
                  rows_rem       <= eh - 32'd1;
                  avl_burstbegin <= 1'b1;
               end
            end
            S_WRITE: begin
               if (accept) begin
                  avl_burstbegin <= 1'b0;
                  if (!last_beat) begin
                     beats_left <= beats_left - 32'd1;
                  end else if (row_rem != 32'd0) begin
                     // next burst in the same row
                     avl_address    <= avl_address + (32'(avl_burstcount) << 2);
                     avl_burstcount <= next_len[BCW-1:0];
                     beats_left     <= next_len;
                     row_rem        <= row_rem - next_len;
                     avl_burstbegin <= 1'b1;
                  end else if (rows_rem != 32'd0) begin
                     // first burst of the next row
                     row_addr       <= row_addr + STRIDE;
                     avl_address    <= row_addr + STRIDE;
                     avl_burstcount <= first_len[BCW-1:0];
                     beats_left     <= first_len;
                     row_rem        <= ew - first_len;
                     rows_rem       <= rows_rem - 32'd1;
                     avl_burstbegin <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_avl_rect_fill.sv
`default_nettype none
// ============================================================================
//  Module   : tb_avl_rect_fill
//  Purpose  : Self-checking bench for avl_rect_fill. Each command pushes the
//             expected beat sequence to a scoreboard; a monitor pops and
//             compares every accepted beat and checks stall holding and
//             completion timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_avl_rect_fill;

    localparam int          FRAME_W   = 800;
    localparam int          FRAME_H   = 480;
    localparam logic [31:0] BASE_ADDR = 32'h2000_0000;
    localparam int          MAX_BURST = 16;
    localparam int          BCW       = 5;
`ifdef AVL_BURST_EN
    localparam int          BL        = MAX_BURST;
`else
    localparam int          BL        = 1;
`endif
    localparam logic [BCW-1:0] EXP_BC0 = BCW'(BL);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [9:0]     x0 = '0, y0 = '0, w = '0, h = '0;
    logic [31:0]    color = '0;
    logic           busy, done;
    logic           waitreq = 1'b0;
    logic [31:0]    addr, wdata;
    logic           write, read, bb;
    logic [BCW-1:0] bc;

    always #5 clk = ~clk;

    avl_rect_fill #(
        .FRAME_W(FRAME_W), .FRAME_H(FRAME_H), .BASE_ADDR(BASE_ADDR),
        .MAX_BURST(MAX_BURST), .BCW(BCW), .XW(10), .YW(10)
    ) dut (
        .iCLK(clk), .iRST_n(rst_n), .iStart(start),
        .iX0(x0), .iY0(y0), .iW(w), .iH(h), .iColor(color),
        .oBusy(busy), .oDone(done),
        .avl_waitrequest(waitreq), .avl_address(addr), .avl_writedata(wdata),
        .avl_write(write), .avl_read(read), .avl_burstbegin(bb),
        .avl_burstcount(bc)
    );

    typedef struct packed {
        logic [31:0]    a;
        logic [31:0]    d;
        logic [BCW-1:0] bc;
        logic           bb;
    } beat_t;

    beat_t  sb[$];
    int     vectors = 0;
    int     miscompares = 0;
    longint cyc = 0;
    int     wr_mode = 0;
    longint acc_edge = 0;
    bit     acc_seen = 1'b0;
    bit     prev_stall = 1'b0;
    beat_t  prev, cur, exp_b;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        case (wr_mode)
            0:       waitreq = 1'b0;
            1:       waitreq = 1'($urandom_range(0, 1));
            default: waitreq = 1'b1;
        endcase
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            cur = '{addr, wdata, bc, bb};
            if (prev_stall) chk("stall_hold", {write, cur}, {1'b1, prev});
            if (write && !waitreq) begin
                chk("beat_expected", (sb.size() != 0), 1'b1);
                if (sb.size() != 0) begin
                    exp_b = sb.pop_front();
                    chk("beat", cur, exp_b);
                end
                acc_edge = cyc + 1;
                acc_seen = 1'b1;
            end
            prev_stall = write && waitreq;
            prev       = cur;
            if (done && acc_seen) begin
                chk("done_latency", cyc, acc_edge);
                chk("done_sb_empty", sb.size(), 0);
                acc_seen = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_cmd(input int cx, input int cy, input int cw, input int ch,
                            input logic [31:0] col);
        int ew, eh, rem, len;
        logic [31:0] a;
        if (cx >= FRAME_W || cy >= FRAME_H) return;
        ew = (cw < FRAME_W - cx) ? cw : FRAME_W - cx;
        eh = (ch < FRAME_H - cy) ? ch : FRAME_H - cy;
        for (int r = 0; r < eh; r++) begin
            a   = BASE_ADDR + 32'(((cy + r) * FRAME_W + cx) * 4);
            rem = ew;
            while (rem > 0) begin
                len = (rem < BL) ? rem : BL;
                for (int b = 0; b < len; b++)
                    sb.push_back('{a, col, BCW'(len), (b == 0)});
                a   = a + 32'(len * 4);
                rem = rem - len;
            end
        end
    endtask

    task automatic start_cmd(input int cx, input int cy, input int cw, input int ch,
                             input logic [31:0] col);
        x0 = 10'(cx); y0 = 10'(cy); w = 10'(cw); h = 10'(ch); color = col;
        start = 1'b1;
        push_cmd(cx, cy, cw, ch, col);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string tag);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(tag, done, 1'b1);
    endtask

    initial begin
        tick(3);
        chk("rst_busy",  busy,  1'b0);
        chk("rst_done",  done,  1'b0);
        chk("rst_write", write, 1'b0);
        chk("rst_read",  read,  1'b0);
        chk("rst_bb",    bb,    1'b0);
        chk("rst_bc",    bc,    {BCW{1'b0}});
        chk("rst_addr",  addr,  32'h0);
        chk("rst_wdata", wdata, 32'h0);
        rst_n = 1'b1;
        tick(1);

        start_cmd(150, 150, 200, 150, 32'h00FF_E4C4);
        chk("setup_write", write, 1'b0);
        chk("setup_busy",  busy,  1'b1);
        tick(1);
        chk("first_write", write, 1'b1);
        chk("first_addr",  addr,  32'h2007_5558);
        chk("first_bb",    bb,    1'b1);
        chk("first_bc",    bc,    EXP_BC0);
        chk("first_data",  wdata, 32'h00FF_E4C4);
        wait_done(40000, "done_big");
        tick(1);

        wr_mode = 1;
        start_cmd(10, 20, 40, 3, 32'hA5A5_0001);
        tick(20);
        x0 = 10'd0; y0 = 10'd0; w = 10'd5; h = 10'd5; color = 32'hDEAD_BEEF;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(2000, "done_stall");
        wr_mode = 0;
        tick(1);

        start_cmd(790, 475, 20, 20, 32'h1234_5678);
        wait_done(500, "done_clip");
        tick(1);

        start_cmd(800, 10, 5, 5, 32'h0BAD_0BAD);
        chk("empty_done_n1", done, 1'b0);
        tick(1);
        chk("empty_done_n2", done,  1'b1);
        chk("empty_busy_n2", busy,  1'b1);
        chk("empty_write",   write, 1'b0);
        tick(1);
        chk("empty_done_off", done, 1'b0);
        chk("empty_busy_off", busy, 1'b0);

        start_cmd(0, 0, 2, 1, 32'h0000_00FF);
        wait_done(100, "done_b2b");
        tick(1);

        wr_mode = 2;
        start_cmd(300, 200, 40, 4, 32'h5555_AAAA);
        tick(4);
        chk("stalled_write", write, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_write", write, 1'b0);
        chk("rst_mid_busy",  busy,  1'b0);
        chk("rst_mid_addr",  addr,  32'h0);
        chk("rst_mid_bb",    bb,    1'b0);
        sb.delete();
        acc_seen = 1'b0;
        wr_mode  = 0;
        tick(2);
        rst_n = 1'b1;
        tick(1);

        start_cmd(5, 7, 3, 2, 32'hCAFE_F00D);
        tick(1);
        chk("post_rst_addr", addr, 32'h2000_5794);
        chk("post_rst_bc",   bc,   BCW'((BL < 3) ? BL : 3));
        wait_done(100, "done_post_rst");
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
